// File: rtl/bidsn_pkg.sv
// Shared types and codes for the N-bidder auction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bidsn_pkg;

    // Host opcodes; encodings 9..15 are decoded as NoOperation.
    typedef enum logic [3:0] {
        NoOperation = 4'd0,
        Unlock      = 4'd1,
        Lock        = 4'd2,
        LoadBal     = 4'd3,
        SetMask     = 4'd4,
        SetTimer    = 4'd5,
        BidCharge   = 4'd6,
        RoundActive = 4'd7,
        RoundOver   = 4'd8
    } operation_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    // Host error codes on err.
    localparam logic [2:0] ERR_NONE      = 3'b000;
    localparam logic [2:0] ERR_BADKEY    = 3'b001;
    localparam logic [2:0] ERR_LOCKED    = 3'b010;
    localparam logic [2:0] ERR_INROUND   = 3'b011;
    localparam logic [2:0] ERR_ZEROTIMER = 3'b100;
    localparam logic [2:0] ERR_NOROUND   = 3'b101;

    // Per-bidder result codes on bidErr.
    localparam logic [1:0] BID_OK       = 2'b00;
    localparam logic [1:0] BID_INACTIVE = 2'b01;
    localparam logic [1:0] BID_NOFUNDS  = 2'b10;
    localparam logic [1:0] BID_LOW      = 2'b11;

endpackage

// File: rtl/bidsn_controller_if.sv
// Host op bus plus per-bidder bid/retract lanes and their registered results.
// Latency: n/a (wiring only).
// Backpressure: host must only issue ops while ready=1; bidder lanes have none.
interface bidsn_controller_if #(
    parameter int NUM_BIDDERS = 3,
    parameter int BID_W       = 16,
    parameter int DATA_W      = 32
);
    localparam int IDX_W = (NUM_BIDDERS > 1) ? $clog2(NUM_BIDDERS) : 1;

    logic                          C_start;
    logic [3:0]                    C_op;
    logic [IDX_W-1:0]              C_sel;
    logic [DATA_W-1:0]             C_data;
    logic [NUM_BIDDERS-1:0]        bid;
    logic [NUM_BIDDERS*BID_W-1:0]  bidAmt;
    logic [NUM_BIDDERS-1:0]        retract;

    logic [NUM_BIDDERS-1:0]        ack;
    logic [NUM_BIDDERS*2-1:0]      bidErr;
    logic [NUM_BIDDERS*DATA_W-1:0] balance;
    logic [NUM_BIDDERS-1:0]        win;
    logic                          ready;
    logic [2:0]                    err;
    logic                          roundOver;
    logic [DATA_W-1:0]             maxBid;

    modport master (
        output C_start, C_op, C_sel, C_data, bid, bidAmt, retract,
        input  ack, bidErr, balance, win, ready, err, roundOver, maxBid
    );

    modport slave (
        input  C_start, C_op, C_sel, C_data, bid, bidAmt, retract,
        output ack, bidErr, balance, win, ready, err, roundOver, maxBid
    );

endinterface

// File: rtl/bidsn_arbiter.sv
// Picks the highest-amount candidate among valid bids, lowest index on ties.
// Latency: combinational.
// Backpressure: none.
module bidsn_arbiter #(
    parameter int NUM_BIDDERS = 3,
    parameter int BID_W       = 16,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_BIDDERS-1:0]       cand_vld,
    input  logic [NUM_BIDDERS*BID_W-1:0] cand_amt,
    output logic [IDX_W-1:0]             sel_idx,
    output logic                         sel_vld
);

    logic [BID_W-1:0] best_amt;

    // Ascending scan with strict greater-than keeps the lowest index on ties.
    always_comb begin
        sel_idx  = '0;
        sel_vld  = 1'b0;
        best_amt = '0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (cand_vld[i] && (!sel_vld || (cand_amt[i*BID_W +: BID_W] > best_amt))) begin
                sel_vld  = 1'b1;
                sel_idx  = IDX_W'(i);
                best_amt = cand_amt[i*BID_W +: BID_W];
            end
        end
    end

endmodule

// File: rtl/bidsn_controller.sv
// Timed N-bidder auction: host ops, per-bidder bid/retract arbitration, settlement.
// Latency: every effect is registered and visible the cycle after sampling.
// Backpressure: ready drops only for the single settlement cycle; host ops then are dropped.
module bidsn_controller
    import bidsn_pkg::*;
#(
    parameter int NUM_BIDDERS = 3,
    parameter int BID_W       = 16,
    parameter int DATA_W      = 32,
    parameter int TIMER_W     = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    bidsn_controller_if.slave bus
);

    localparam int IDX_W = (NUM_BIDDERS > 1) ? $clog2(NUM_BIDDERS) : 1;

    state_t                  state_q, state_nxt;
    logic [DATA_W-1:0]       key_q, charge_q, max_q, max_nxt;
    logic [NUM_BIDDERS-1:0]  mask_q;
    logic [TIMER_W-1:0]      tload_q, timer_q;
    logic [DATA_W-1:0]       bal_q   [NUM_BIDDERS];
    logic [DATA_W-1:0]       bal_nxt [NUM_BIDDERS];
    logic [BID_W-1:0]        amt_w   [NUM_BIDDERS];
    logic [IDX_W-1:0]        leader_q, leader_nxt;
    logic                    leader_vld_q, leader_vld_nxt, leader_drop;

    logic [NUM_BIDDERS-1:0]   ack_q, ack_nxt, win_q, win_nxt, bid_ok;
    logic [NUM_BIDDERS*2-1:0] bid_err_q, bid_err_nxt;
    logic                     ready_q, round_over_q;
    logic [2:0]               err_q, err_nxt;

    logic host_go, active;
    logic do_lock, do_load, do_mask, do_tload, do_charge, do_start, do_settle;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;

    assign host_go = bus.C_start && ready_q;
    assign active  = (state_q == ST_ACTIVE);

    for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_lane
        assign amt_w[g] = bus.bidAmt[g*BID_W +: BID_W];
        assign bus.balance[g*DATA_W +: DATA_W] = bal_q[g];
    end

    // Round-phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_UNLOCKED;
        else          state_q <= state_nxt;
    end

    // Host op decode per phase, round-end detection and next phase.
    always_comb begin
        state_nxt = state_q;
        err_nxt   = ERR_NONE;
        do_lock   = 1'b0;
        do_load   = 1'b0;
        do_mask   = 1'b0;
        do_tload  = 1'b0;
        do_charge = 1'b0;
        do_start  = 1'b0;
        do_settle = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (host_go) begin
                    case (bus.C_op)
                        Lock:        begin do_lock = 1'b1; state_nxt = ST_LOCKED; end
                        LoadBal:     do_load   = 1'b1;
                        SetMask:     do_mask   = 1'b1;
                        SetTimer:    do_tload  = 1'b1;
                        BidCharge:   do_charge = 1'b1;
                        RoundActive: begin
                            if (tload_q == '0) begin
                                err_nxt = ERR_ZEROTIMER;
                            end else begin
                                do_start  = 1'b1;
                                state_nxt = ST_ACTIVE;
                            end
                        end
                        RoundOver:   err_nxt = ERR_NOROUND;
                        default:     ;
                    endcase
                end
            end
            ST_LOCKED: begin
                if (host_go) begin
                    case (bus.C_op)
                        Unlock: begin
                            if (bus.C_data == key_q) state_nxt = ST_UNLOCKED;
                            else                     err_nxt   = ERR_BADKEY;
                        end
                        Lock, LoadBal, SetMask, SetTimer, BidCharge, RoundActive, RoundOver:
                            err_nxt = ERR_LOCKED;
                        default: ;
                    endcase
                end
            end
            ST_ACTIVE: begin
                if (host_go) begin
                    case (bus.C_op)
                        RoundOver: do_settle = 1'b1;
                        Unlock, Lock, LoadBal, SetMask, SetTimer, BidCharge, RoundActive:
                            err_nxt = ERR_INROUND;
                        default: ;
                    endcase
                end
                // Timer hits zero at the end of this cycle; one settlement even if host also ends it.
                if (timer_q == TIMER_W'(1)) do_settle = 1'b1;
                if (do_settle) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: state_nxt = ST_UNLOCKED;
            default:   state_nxt = ST_UNLOCKED;
        endcase
    end

    // Classify each bidder's strobe against last cycle's maxBid and balances.
    always_comb begin
        ack_nxt     = '0;
        bid_ok      = '0;
        bid_err_nxt = '0;
        leader_drop = 1'b0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (bus.retract[i]) begin
                if (!active) begin
                    bid_err_nxt[i*2 +: 2] = BID_INACTIVE;
                end else if (leader_vld_q && (leader_q == IDX_W'(i))) begin
                    ack_nxt[i]  = 1'b1;
                    leader_drop = 1'b1;
                end else begin
                    bid_err_nxt[i*2 +: 2] = BID_LOW;
                end
            end else if (bus.bid[i]) begin
                if (!active || !mask_q[i]) begin
                    bid_err_nxt[i*2 +: 2] = BID_INACTIVE;
                end else if (DATA_W'(amt_w[i]) <= max_q) begin
                    bid_err_nxt[i*2 +: 2] = BID_LOW;
                end else if ({1'b0, bal_q[i]} < ({1'b0, charge_q} + (DATA_W+1)'(amt_w[i]))) begin
                    bid_err_nxt[i*2 +: 2] = BID_NOFUNDS;
                end else begin
                    ack_nxt[i] = 1'b1;
                    bid_ok[i]  = 1'b1;
                end
            end
        end
    end

    bidsn_arbiter #(
        .NUM_BIDDERS (NUM_BIDDERS),
        .BID_W       (BID_W),
        .IDX_W       (IDX_W)
    ) u_arbiter (
        .cand_vld (bid_ok),
        .cand_amt (bus.bidAmt),
        .sel_idx  (arb_idx),
        .sel_vld  (arb_vld)
    );

    // Balances, leader and high bid after charges, host loads and settlement.
    always_comb begin
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            bal_nxt[i] = bal_q[i];
            if (bid_ok[i]) bal_nxt[i] = bal_q[i] - charge_q;
            if (do_load && (bus.C_sel == IDX_W'(i))) bal_nxt[i] = bus.C_data;
        end
        max_nxt        = max_q;
        leader_nxt     = leader_q;
        leader_vld_nxt = leader_vld_q;
        win_nxt        = '0;
        if (do_start) begin
            max_nxt        = '0;
            leader_vld_nxt = 1'b0;
        end else if (arb_vld) begin
            leader_nxt     = arb_idx;
            leader_vld_nxt = 1'b1;
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (arb_idx == IDX_W'(i)) max_nxt = DATA_W'(amt_w[i]);
            end
        end else if (leader_drop) begin
            leader_vld_nxt = 1'b0;
        end
        // Settlement sees bids made on the final cycle, so it uses the post-bid leader.
        if (do_settle && leader_vld_nxt) begin
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (leader_nxt == IDX_W'(i)) begin
                    win_nxt[i] = 1'b1;
                    bal_nxt[i] = bal_nxt[i] - max_nxt;
                end
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q        <= '0;
            charge_q     <= '0;
            mask_q       <= '1;
            tload_q      <= '0;
            timer_q      <= '0;
            max_q        <= '0;
            leader_q     <= '0;
            leader_vld_q <= 1'b0;
            for (int i = 0; i < NUM_BIDDERS; i++) bal_q[i] <= '0;
            ack_q        <= '0;
            bid_err_q    <= '0;
            win_q        <= '0;
            ready_q      <= 1'b1;
            err_q        <= ERR_NONE;
            round_over_q <= 1'b0;
        end else begin
            if (do_lock)   key_q    <= bus.C_data;
            if (do_charge) charge_q <= bus.C_data;
            if (do_mask)   mask_q   <= bus.C_data[NUM_BIDDERS-1:0];
            if (do_tload)  tload_q  <= bus.C_data[TIMER_W-1:0];
            if (do_start)     timer_q <= tload_q;
            else if (active)  timer_q <= timer_q - TIMER_W'(1);
            max_q        <= max_nxt;
            leader_q     <= leader_nxt;
            leader_vld_q <= leader_vld_nxt;
            for (int i = 0; i < NUM_BIDDERS; i++) bal_q[i] <= bal_nxt[i];
            ack_q        <= ack_nxt;
            bid_err_q    <= bid_err_nxt;
            win_q        <= win_nxt;
            ready_q      <= (state_nxt != ST_SETTLE);
            err_q        <= err_nxt;
            round_over_q <= do_settle;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.bidErr    = bid_err_q;
    assign bus.win       = win_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.roundOver = round_over_q;
    assign bus.maxBid    = max_q;

endmodule

// File: tb/tb_bidsn_controller.sv
// Directed scenarios plus random traffic against a cycle-numbered auction model.
// Latency: expects every effect one clock after the inputs are sampled.
// Backpressure: host strobes during the settlement cycle must be dropped silently.
module tb_bidsn_controller;
    import bidsn_pkg::*;

    localparam int N       = 3;
    localparam int BID_W   = 16;
    localparam int DATA_W  = 32;
    localparam int TIMER_W = 16;
    localparam int IDX_W   = $clog2(N);

    localparam int M_UNL = 0, M_LCK = 1, M_ACT = 2, M_SET = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    bidsn_controller_if #(.NUM_BIDDERS(N), .BID_W(BID_W), .DATA_W(DATA_W)) bus ();

    bidsn_controller #(
        .NUM_BIDDERS (N),
        .BID_W       (BID_W),
        .DATA_W      (DATA_W),
        .TIMER_W     (TIMER_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the current cycle.
    logic             s_start;
    logic [3:0]       s_op;
    logic [IDX_W-1:0] s_sel;
    logic [31:0]      s_data;
    logic [N-1:0]     s_bid, s_ret;
    logic [15:0]      s_amt [N];

    // Reference model state, expressed in round-end cycle numbers rather than a countdown.
    int          m_mode;
    logic [31:0] m_key, m_charge, m_max;
    logic [N-1:0] m_mask;
    int          m_tload;
    int          m_leader;
    longint      m_cycle, m_end;
    logic [31:0] m_bal [N];

    logic [N-1:0] e_ack, e_win;
    logic [1:0]   e_code [N];
    logic [2:0]   e_err;
    logic         e_ready, e_ro;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        s_start = 1'b0; s_op = 4'd0; s_sel = '0; s_data = '0;
        s_bid = '0; s_ret = '0;
        for (int i = 0; i < N; i++) s_amt[i] = '0;
    endtask

    task automatic drive();
        logic [N*BID_W-1:0] amts;
        for (int i = 0; i < N; i++) amts[i*BID_W +: BID_W] = s_amt[i];
        bus.C_start = s_start; bus.C_op = s_op; bus.C_sel = s_sel; bus.C_data = s_data;
        bus.bid = s_bid; bus.retract = s_ret; bus.bidAmt = amts;
    endtask

    task automatic model_reset();
        m_mode = M_UNL; m_key = '0; m_charge = '0; m_max = '0; m_mask = '1;
        m_tload = 0; m_leader = -1; m_end = -1;
        for (int i = 0; i < N; i++) begin m_bal[i] = '0; e_code[i] = 2'b00; end
        e_ack = '0; e_win = '0; e_err = 3'b000; e_ready = 1'b1; e_ro = 1'b0;
    endtask

    task automatic model_step();
        bit go, act, settle, start, dropped;
        int op, nxt, top;
        bit ok [N];
        go = s_start && (m_mode != M_SET);
        act = (m_mode == M_ACT);
        op = int'(s_op);
        if (op > 8) op = 0;
        nxt = m_mode; settle = 0; start = 0; dropped = 0;
        e_ack = '0; e_win = '0; e_err = 3'b000; e_ro = 1'b0;
        for (int i = 0; i < N; i++) begin e_code[i] = 2'b00; ok[i] = 0; end
        if (go) begin
            if (m_mode == M_UNL) begin
                case (op)
                    2: begin m_key = s_data; nxt = M_LCK; end
                    3: m_bal[s_sel] = s_data;
                    4: m_mask = s_data[N-1:0];
                    5: m_tload = int'(s_data[15:0]);
                    6: m_charge = s_data;
                    7: if (m_tload == 0) e_err = 3'b100; else start = 1;
                    8: e_err = 3'b101;
                    default: ;
                endcase
            end else if (m_mode == M_LCK) begin
                if (op == 1) begin
                    if (s_data == m_key) nxt = M_UNL; else e_err = 3'b001;
                end else if (op != 0) e_err = 3'b010;
            end else if (m_mode == M_ACT) begin
                if (op == 8) settle = 1; else if (op != 0) e_err = 3'b011;
            end
        end
        if (act && m_cycle == m_end) settle = 1;
        // Bids and retracts judged against values held before this cycle.
        top = -1;
        for (int i = 0; i < N; i++) begin
            if (s_ret[i]) begin
                if (!act) e_code[i] = 2'b01;
                else if (m_leader == i) begin e_ack[i] = 1; dropped = 1; end
                else e_code[i] = 2'b11;
            end else if (s_bid[i]) begin
                if (!act || !m_mask[i]) e_code[i] = 2'b01;
                else if (longint'(s_amt[i]) <= longint'(m_max)) e_code[i] = 2'b11;
                else if (longint'(m_bal[i]) < longint'(m_charge) + longint'(s_amt[i])) e_code[i] = 2'b10;
                else begin ok[i] = 1; e_ack[i] = 1; end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ok[i]) begin
                m_bal[i] = m_bal[i] - m_charge;
                if (int'(s_amt[i]) > top) top = int'(s_amt[i]);
            end
        end
        if (top >= 0) begin
            m_max = 32'(top);
            for (int i = N - 1; i >= 0; i--) if (ok[i] && int'(s_amt[i]) == top) m_leader = i;
        end else if (dropped) m_leader = -1;
        if (start) begin
            m_max = '0; m_leader = -1; m_end = m_cycle + longint'(m_tload); nxt = M_ACT;
        end
        if (settle) begin
            if (m_leader >= 0) begin
                m_bal[m_leader] = m_bal[m_leader] - m_max;
                e_win[m_leader] = 1'b1;
            end
            e_ro = 1'b1;
            nxt = M_SET;
        end
        if (m_mode == M_SET) nxt = M_UNL;
        m_mode = nxt;
        e_ready = (nxt != M_SET);
    endtask

    task automatic compare_all();
        logic [2*N-1:0] exp_be;
        for (int i = 0; i < N; i++) exp_be[i*2 +: 2] = e_code[i];
        chk("ack", 64'(bus.ack), 64'(e_ack));
        chk("bidErr", 64'(bus.bidErr), 64'(exp_be));
        chk("win", 64'(bus.win), 64'(e_win));
        chk("ready", 64'(bus.ready), 64'(e_ready));
        chk("err", 64'(bus.err), 64'(e_err));
        chk("roundOver", 64'(bus.roundOver), 64'(e_ro));
        chk("maxBid", 64'(bus.maxBid), 64'(m_max));
        for (int i = 0; i < N; i++)
            chk($sformatf("balance%0d", i), 64'(bus.balance[i*DATA_W +: DATA_W]), 64'(m_bal[i]));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic run_cycle();
        drive();
        if (reset_n) model_step(); else model_reset();
        m_cycle++;
        @(posedge clk);
        #2;
        compare_all();
        @(negedge clk);
    endtask

    task automatic host(input int op, input logic [31:0] data, input int sel);
        set_idle();
        s_start = 1'b1; s_op = 4'(op); s_data = data; s_sel = IDX_W'(sel);
        run_cycle();
    endtask

    task automatic wait_round_over(input int limit, output int waited);
        set_idle();
        waited = 0;
        while (!bus.roundOver && waited < limit) begin
            run_cycle();
            waited++;
        end
        chk("round_over_seen", 64'(bus.roundOver), 64'd1);
    endtask

    function automatic logic [1:0] code_of(input int i);
        logic [2*N-1:0] v;
        v = bus.bidErr;
        return v[i*2 +: 2];
    endfunction

    function automatic logic [31:0] bal_of(input int i);
        logic [N*DATA_W-1:0] v;
        v = bus.balance;
        return v[i*DATA_W +: DATA_W];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, r, k;
        m_cycle = 0;
        set_idle();
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_ready", 64'(bus.ready), 64'd1);
        reset_n = 1'b1;

        // Key lock / unlock.
        host(2, 32'hA5A5, 0);
        host(1, 32'h1234, 0);
        chk("bad_key_err", 64'(bus.err), 64'd1);
        host(1, 32'hA5A5, 0);
        chk("good_key_err", 64'(bus.err), 64'd0);
        host(4, 32'h7, 0);
        chk("mask_after_unlock_err", 64'(bus.err), 64'd0);

        // Single bidder wins at timer expiry.
        for (int i = 0; i < N; i++) host(3, 32'd100, i);
        host(6, 32'd5, 0);
        host(5, 32'd10, 0);
        host(7, 32'd0, 0);
        set_idle(); s_bid[1] = 1'b1; s_amt[1] = 16'd40;
        run_cycle();
        chk("bid1_ack", 64'(bus.ack), 64'b010);
        chk("bid1_charged", 64'(bal_of(1)), 64'd95);
        wait_round_over(20, waited);
        chk("round_length", 64'(waited), 64'd9);
        chk("win1", 64'(bus.win), 64'b010);
        chk("win1_balance", 64'(bal_of(1)), 64'd55);
        chk("win1_maxbid", 64'(bus.maxBid), 64'd40);
        chk("settle_ready", 64'(bus.ready), 64'd0);
        host(2, 32'hBEEF, 0);  // dropped: ready is low
        chk("settle_op_ignored", 64'(bus.err), 64'd0);
        chk("ready_back", 64'(bus.ready), 64'd1);

        // Funds shortfall, tie, low rebid, leader retract, host end.
        host(3, 32'd20, 1);
        host(7, 32'd0, 0);
        set_idle(); s_bid[1] = 1'b1; s_amt[1] = 16'd16;
        run_cycle();
        chk("nofunds_code", 64'(code_of(1)), 64'b10);
        chk("nofunds_balance", 64'(bal_of(1)), 64'd20);
        set_idle(); s_bid = 3'b101; s_amt[0] = 16'd30; s_amt[2] = 16'd30;
        run_cycle();
        chk("tie_ack", 64'(bus.ack), 64'b101);
        chk("tie_bal0", 64'(bal_of(0)), 64'd95);
        chk("tie_bal2", 64'(bal_of(2)), 64'd95);
        chk("tie_maxbid", 64'(bus.maxBid), 64'd30);
        set_idle(); s_bid[2] = 1'b1; s_amt[2] = 16'd30;
        run_cycle();
        chk("equal_bid_code", 64'(code_of(2)), 64'b11);
        host(6, 32'd9, 0);
        chk("op_in_round_err", 64'(bus.err), 64'd3);
        set_idle(); s_ret[0] = 1'b1;
        run_cycle();
        chk("retract_ack", 64'(bus.ack), 64'b001);
        host(8, 32'd0, 0);
        chk("retract_round_over", 64'(bus.roundOver), 64'd1);
        chk("retract_no_win", 64'(bus.win), 64'd0);
        chk("retract_maxbid_kept", 64'(bus.maxBid), 64'd30);
        set_idle(); run_cycle();
        host(8, 32'd0, 0);
        chk("no_round_err", 64'(bus.err), 64'd5);

        // Zero timer, masked bidder, reset mid-round.
        host(4, 32'b101, 0);
        host(5, 32'd0, 0);
        host(7, 32'd0, 0);
        chk("zero_timer_err", 64'(bus.err), 64'd4);
        host(5, 32'd10, 0);
        host(7, 32'd0, 0);
        set_idle(); s_bid[1] = 1'b1; s_amt[1] = 16'd50;
        run_cycle();
        chk("masked_code", 64'(code_of(1)), 64'b01);
        set_idle();
        repeat (6) run_cycle();
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("reset_mid_ready", 64'(bus.ready), 64'd1);
        @(negedge clk);
        set_idle();
        repeat (2) run_cycle();
        reset_n = 1'b1;
        repeat (4) run_cycle();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            set_idle();
            r = $urandom_range(0, 99);
            if (r < 55) begin
                s_start = 1'b1;
                k = $urandom_range(0, 99);
                s_sel = IDX_W'($urandom_range(0, N - 1));
                if (k < 5)       begin s_op = 4'd2; s_data = ($urandom_range(0, 1) != 0) ? 32'hA5A5 : 32'h1234; end
                else if (k < 18) begin s_op = 4'd1; s_data = ($urandom_range(0, 1) != 0) ? 32'hA5A5 : 32'h1234; end
                else if (k < 35) begin s_op = 4'd3; s_data = 32'($urandom_range(0, 200)); end
                else if (k < 40) begin s_op = 4'd4; s_data = 32'($urandom_range(0, 7) | (($urandom_range(0, 1) != 0) ? 7 : 0)); end
                else if (k < 48) begin s_op = 4'd5; s_data = 32'($urandom_range(0, 8)); end
                else if (k < 53) begin s_op = 4'd6; s_data = 32'($urandom_range(0, 6)); end
                else if (k < 70) begin s_op = 4'd7; end
                else if (k < 75) begin s_op = 4'd8; end
                else if (k < 80) begin s_op = 4'($urandom_range(9, 15)); end
                else             begin s_op = 4'd0; end
            end
            for (int i = 0; i < N; i++) begin
                s_bid[i] = ($urandom_range(0, 99) < 30);
                s_ret[i] = ($urandom_range(0, 99) < 6);
                s_amt[i] = 16'($urandom_range(0, 50));
            end
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bidsn_controller.md
# bidsn_controller

Parametrised N-bidder auction controller, successor to the fixed three-bidder (X/Y/Z) BIDS22 controller. It accepts host opcodes (lock/unlock, balance loads, mask, timer, bid charge, round start/stop) and arbitrates bids and retracts from `NUM_BIDDERS` bidders. It runs a timed round and settles the winner's balance. It sits behind the BIDS22-style BFM/tester, now driven with per-bidder vectors instead of X/Y/Z scalars.

## Interface
- `NUM_BIDDERS`, 3: bidder count, 2..16.
- `BID_W`, 16: bid amount width.
- `DATA_W`, 32: host data / balance / maxBid width.
- `TIMER_W`, 16: round timer width (low bits of `C_data`).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `C_start` in 1: host op strobe, sampled when `ready`=1.
- `C_op` in 4: `operation_t` from `bidsn_pkg`.
- `C_sel` in $clog2(NUM_BIDDERS): bidder index for LoadBal.
- `C_data` in DATA_W: op operand.
- `bid` in NUM_BIDDERS: per-bidder bid strobe.
- `bidAmt` in NUM_BIDDERS*BID_W: packed amounts; bidder i at [i*BID_W +: BID_W].
- `retract` in NUM_BIDDERS: per-bidder retract strobe.
- `ack` out NUM_BIDDERS: one-cycle pulse, bid or retract accepted.
- `bidErr` out NUM_BIDDERS*2: per-bidder error code, one-cycle.
- `balance` out NUM_BIDDERS*DATA_W: current balances.
- `win` out NUM_BIDDERS: one-hot winner pulse.
- `ready` out 1: host may issue an op.
- `err` out 3: host error code, one-cycle.
- `roundOver` out 1: one-cycle pulse at settlement.
- `maxBid` out DATA_W: current or last-round high bid, zero-extended.

## Operation
- States: UNLOCKED (reset), LOCKED, ACTIVE, SETTLE.
- UNLOCKED ops:
  - Lock: key<=C_data, go to LOCKED.
  - LoadBal: balance[C_sel]<=C_data.
  - SetMask: mask<=C_data[NUM_BIDDERS-1:0].
  - SetTimer: tload<=C_data[TIMER_W-1:0].
  - BidCharge: charge<=C_data.
  - RoundActive: timer<=tload, maxBid<=0, leader invalid, go to ACTIVE.
  - RoundActive with tload=0: err=100, no state change.
  - NoOperation: no effect.
  - Unlock: no-op.
  - RoundOver: err=101.
- LOCKED ops:
  - Unlock with C_data==key: go to UNLOCKED.
  - Unlock with any other C_data: err=001.
  - Any other op except NoOperation: err=010.
- ACTIVE ops:
  - RoundOver: go to SETTLE.
  - NoOperation: no effect.
  - All other ops: err=011.
- ACTIVE timer: decrements every cycle; transition to SETTLE on the cycle it reaches 0.
- Bid from bidder i, evaluated against maxBid and balances registered before the current cycle:
  - masked or state≠ACTIVE: code 01.
  - bidAmt≤maxBid: code 11.
  - balance<charge+bidAmt (DATA_W+1-bit compare): code 10.
  - otherwise valid: ack, balance-=charge.
- Among valid bids in the same cycle, the highest amount becomes leader; ties go to the lowest index. maxBid<=that amount.
- Retract:
  - By the leader: ack, leader invalid, maxBid unchanged, no charge.
  - By a non-leader: code 11.
  - Outside ACTIVE: code 01.
  - Retract and bid from the same bidder in the same cycle: retract wins, bid ignored.
- SETTLE (one cycle):
  - If leader valid: balance[leader]-=maxBid, win[leader]=1.
  - roundOver=1 in all cases.
  - ready=0.
  - Go to UNLOCKED.
- Unknown C_op encodings: treated as NoOperation.

## Timing
- All outputs registered; effects visible the cycle after sampling.
- Reset values:
  - ack, bidErr, win, err, roundOver, maxBid, balance: 0.
  - ready=1.
  - mask all ones.
  - key, charge, tload, timer: 0.
  - leader invalid.
- `ready`=0 only in SETTLE. C_start while ready=0 is ignored, no error.
- Round length: RoundActive sampled at cycle t gives ACTIVE for cycles t+1..t+tload; roundOver pulses at t+tload+1.
- A bid on the cycle the timer reaches 0 is still evaluated.
- Host RoundOver and timer expiry in the same cycle: single settlement.
- reset_n low mid-round: immediate return to reset values, no settlement.

## Structure
- `bidsn_pkg`:
  - `operation_t` (4-bit): NoOperation, Unlock, Lock, LoadBal, SetMask, SetTimer, BidCharge, RoundActive, RoundOver.
  - `state_t`.
  - Error-code localparams ERR_NONE, ERR_BADKEY, ERR_LOCKED, ERR_INROUND, ERR_ZEROTIMER, ERR_NOROUND.
  - Bid-code localparams.
- Sub-module `bidsn_arbiter`: combinational highest-amount, lowest-index select over valid bids. Outputs winner index and valid.

## Test plan
- Reset, then Lock C_data=0xA5A5, then Unlock 0x1234 -> err=001. Unlock 0xA5A5 -> UNLOCKED; a following SetMask has err=000.
- LoadBal bidders 0..2 with 100; charge=5, tload=10; RoundActive; bidder1 bids 40 -> ack[1], balance[1]=95; at expiry win[1], balance[1]=55, maxBid=40.
- Same cycle, bidders 0 and 2 both bid 30 -> both acked and charged, leader=0, maxBid=30. Bidder2 bids 30 again -> code 11.
- Bidder with balance 20, charge 5, bids 16 -> code 10, balance unchanged; mask bit cleared -> code 01.
- Leader retracts, round ends -> roundOver=1, no win, maxBid retained. RoundActive with tload=0 -> err=100.
- reset_n asserted at timer=3 -> outputs zero, ready=1, no roundOver.
